// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Memory-stage access controller. Takes the EX/MEM register outputs and
// issues load/store requests to the data memory over a req/ack handshake.
// While a request is outstanding it stalls the upstream pipeline. It also
// produces the MEM/WB write-back fields.
//
// Parameters
//   TIMEOUT    cycles allowed in ACCESS before the request is abandoned (0 = never)
//   TIMEOUT_W  width of the ACCESS cycle counter (TIMEOUT < 2**TIMEOUT_W)
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-low reset
//   inResult                ALU result: byte address for memory ops, else write data
//   inReadRegister2         store data
//   inMemRead, inMemWrite   load / store request (load wins if both set)
//   inWord                  1 = 32-bit access, 0 = byte access
//   inRegWrite, inRd        write-back enable and destination register
//   memReq, memWe, memAddr, memWData, memByteEn
//                           request to data memory, held stable while pending
//   memAck, memRData        completion strobe and load data from memory
//   stall                   combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   outWriteData, outRd, outRegWrite
//                           MEM/WB write-back fields
//   outMemError             one-cycle pulse when a request times out
module mem_access_unit #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inResult,
  input  logic [31:0] inReadRegister2,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic        inWord,
  input  logic        inRegWrite,
  input  logic [4:0]  inRd,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memByteEn,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic        stall,
  output logic [31:0] outWriteData,
  output logic [4:0]  outRd,
  output logic        outRegWrite,
  output logic        outMemError
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  // Last counter value before the request is abandoned.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]           state;
  logic [TIMEOUT_W-1:0] cnt;

  // Instruction fields captured when the request is issued; EX/MEM is
  // frozen by stall meanwhile, but the latched copy keeps the completion
  // path independent of what the upstream register shows.
  logic [1:0] offLat;
  logic       loadLat;
  logic       wordLat;
  logic       regWriteLat;
  logic [4:0] rdLat;

  logic memOp;
  logic isStore;
  logic timeoutHit;

  // One-hot lane for a byte access, all lanes for a word access.
  function automatic logic [3:0] laneEnable(input logic word, input logic [1:0] off);
    logic [3:0] en;
    en = word ? 4'b1111 : (4'b0001 << off);
    return en;
  endfunction

  // A byte store presents the byte on every lane; byte enables pick the target.
  function automatic logic [31:0] storeData(input logic word, input logic [31:0] data);
    logic [31:0] d;
    d = word ? data : {4{data[7:0]}};
    return d;
  endfunction

  // Byte loads are zero-extended from the addressed lane.
  function automatic logic [31:0] loadData(input logic word, input logic [1:0] off,
                                           input logic [31:0] data);
    logic [31:0] d;
    d = word ? data : {24'b0, data[{off, 3'b000} +: 8]};
    return d;
  endfunction

  assign memOp   = inMemRead | inMemWrite;
  assign isStore = inMemWrite & ~inMemRead;

  assign timeoutHit = TIMEOUT_EN && (state == ACCESS) && (cnt == CNT_LAST) && !memAck;

  assign stall = reset & (((state == IDLE) & memOp) |
                          ((state == ACCESS) & ~memAck & ~timeoutHit));

  always_ff @(posedge clock) begin
    outMemError <= 1'b0;
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memWData     <= '0;
      memByteEn    <= '0;
      outWriteData <= '0;
      outRd        <= '0;
      outRegWrite  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memOp) begin
            memReq      <= 1'b1;
            memWe       <= isStore;
            memAddr     <= {inResult[31:2], 2'b00};
            memByteEn   <= laneEnable(inWord, inResult[1:0]);
            memWData    <= storeData(inWord, inReadRegister2);
            offLat      <= inResult[1:0];
            loadLat     <= inMemRead;
            wordLat     <= inWord;
            regWriteLat <= inRegWrite;
            rdLat       <= inRd;
            cnt         <= '0;
            // Bubble into MEM/WB while the access is in flight.
            outRegWrite <= 1'b0;
            state       <= ACCESS;
          end else begin
            outWriteData <= inResult;
            outRd        <= inRd;
            outRegWrite  <= inRegWrite;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (memAck) begin
            memReq <= 1'b0;
            state  <= IDLE;
            if (loadLat) begin
              outWriteData <= loadData(wordLat, offLat, memRData);
            end
            outRd       <= rdLat;
            outRegWrite <= loadLat & regWriteLat;
          end else if (timeoutHit) begin
            memReq      <= 1'b0;
            outRegWrite <= 1'b0;
            outMemError <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller. It consumes the EX/MEM pipeline register outputs and issues load/store requests to the data memory over a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and writes the MEM/WB register fields: write data, destination register and write enable. It sits between the EX/MEM register and the register-file write-back path.

## Interface
- TIMEOUT, 255: maximum cycles in ACCESS before the request is abandoned; 0 disables the timeout.
- TIMEOUT_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^TIMEOUT_W.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- inResult  in  32  ALU result from EX/MEM; memory byte address for loads/stores, write data otherwise.
- inReadRegister2  in  32  store data from EX/MEM.
- inMemRead  in  1  load request.
- inMemWrite  in  1  store request.
- inWord  in  1  1 = 32-bit access, 0 = byte access.
- inRegWrite  in  1  instruction writes rd.
- inRd  in  5  destination register.
- memReq  out  1  request valid to data memory.
- memWe  out  1  1 = store, 0 = load.
- memAddr  out  32  word-aligned address {addr[31:2],2'b00}.
- memWData  out  32  store data.
- memByteEn  out  4  byte-lane enables.
- memAck  in  1  memory completes the request this cycle.
- memRData  in  32  load data, valid when memAck=1.
- stall  out  1  combinational; holds the PC, IF/ID, ID/EX and EX/MEM registers.
- outWriteData  out  32  MEM/WB write-back data.
- outRd  out  5  MEM/WB destination register.
- outRegWrite  out  1  MEM/WB register write enable.
- outMemError  out  1  one-cycle pulse when an access times out.

## Operation
- States: IDLE, ACCESS. A TIMEOUT_W-bit counter `cnt` runs in ACCESS. Latched copies: byte offset `off[1:0]`, load/store kind, inWord, inRegWrite, inRd.
- Memory op present = inMemRead | inMemWrite. If both are set, the access is a load and the store is ignored.
- IDLE, no memory op, on the clock edge:
  - outWriteData <= inResult, outRd <= inRd, outRegWrite <= inRegWrite.
- IDLE, memory op, on the clock edge:
  - memReq <= 1.
  - memWe <= store.
  - memAddr <= aligned inResult.
  - memByteEn <= 4'b1111 if inWord, else a one-hot lane selected by inResult[1:0] (lane 0 = bits 7:0).
  - memWData <= inReadRegister2 for a word access; for a byte access, inReadRegister2[7:0] replicated into all four lanes.
  - Latch the instruction fields, cnt <= 0, outRegWrite <= 0 (bubble), state <= ACCESS.
- ACCESS: memReq and all mem* outputs stay stable. cnt increments each cycle.
- ACCESS, memAck=1, on the clock edge:
  - memReq <= 0, state <= IDLE.
  - Load, word: outWriteData <= memRData.
  - Load, byte: outWriteData <= {24'b0, memRData[8*off+7 -: 8]}.
  - outRd <= latched rd.
  - outRegWrite <= latched RegWrite for a load, 0 for a store.
- ACCESS, TIMEOUT≠0 and cnt == TIMEOUT-1 without memAck, on the clock edge:
  - memReq <= 0, outRegWrite <= 0, outMemError <= 1 for one cycle, state <= IDLE.
  - A later memAck is ignored.
- memAck received in IDLE is ignored.
- stall = reset & ((IDLE & memop) | (ACCESS & ~memAck & ~timeoutHit)).
- Reset (reset=0 at an edge): state IDLE, cnt 0, and memReq, memWe, memAddr, memWData, memByteEn, outWriteData, outRd, outRegWrite and outMemError all 0. stall is 0 while reset=0.
- Reset during ACCESS abandons the request: memReq drops at that edge, and any following ack is ignored.

## Timing
- Non-memory instruction: 1-cycle latency to MEM/WB, no stall.
- Memory op seen in cycle N (stall=1 in N), memReq=1 from N+1.
- If memAck arrives in cycle N+k (k≥1):
  - stall=1 in N..N+k-1 and 0 in N+k.
  - MEM/WB updated at the end of N+k.
  - EX/MEM loads the next instruction at the same edge.
- Minimum load/store cost: 1 stall cycle.
- Timeout: memReq is high for exactly TIMEOUT cycles; outMemError is high in the following cycle.
- The memory must not assert memAck in the cycle after memReq falls for the same request.

## Test plan
- ALU op with inResult=0x1234, inRd=5, inRegWrite=1 -> next cycle outWriteData=0x1234, outRd=5, outRegWrite=1, stall never 1.
- Word load at addr 0x100, memAck in the 3rd ACCESS cycle, memRData=0xDEADBEEF -> stall high 3 cycles; memAddr=0x100, memByteEn=1111, memWe=0; then outWriteData=0xDEADBEEF, outRegWrite=1.
- Byte load at addr 0x102, memRData=0x11223344, ack in the first cycle -> memByteEn=0100, outWriteData=0x00000022, stall high exactly 1 cycle.
- Byte store of inReadRegister2=0xAB at addr 0x203 -> memAddr=0x200, memByteEn=1000, memWData=0xABABABAB, memWe=1; after ack outRegWrite=0.
- TIMEOUT=4, load with no ack -> memReq high 4 cycles, then outMemError=1 for 1 cycle, outRegWrite=0, stall released; a late ack causes no change.
- Assert reset=0 in the 2nd ACCESS cycle -> next cycle memReq=0, all outputs 0, state IDLE; a following ack produces no write-back.
